pipe_vect_skid: RTL and testbench

// - Elastic inter-stage register for the SIMD pipeline, replacing fixed always-advance pipes.
// - Carries one packed control word plus numVec vector operands (vecSize lanes x regSize bits).
// - Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, and per-lane zero masking.
// - Lets the decode/execute/memory stages stall and squash without losing or duplicating instructions.

---
 rtl/pipe_vect_skid.sv | 170 +++++++++++++++++
 tb/tb_pipe_vect_skid.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_vect_skid.sv
// rtl/pipe_vect_skid.sv - elastic SIMD inter-stage register with 2-entry skid buffer
// Optional statistics counters are built when PIPE_VECT_SKID_STATS_EN is defined.
module pipe_vect_skid #(
  parameter int ctrlSize = 33,
  parameter int regSize  = 16,
  parameter int vecSize  = 4,
  parameter int numVec   = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                inValid,
  output logic                                inReady,
  input  logic [ctrlSize-1:0]                 inCtrl,
  input  logic [numVec*vecSize*regSize-1:0]   inVec,
  input  logic [vecSize-1:0]                  inLaneMask,
  output logic                                outValid,
  input  logic                                outReady,
  output logic [ctrlSize-1:0]                 outCtrl,
  output logic [numVec*vecSize*regSize-1:0]   outVec,
  output logic [vecSize-1:0]                  outLaneMask,
  output logic [31:0]                         stallCount,
  output logic [31:0]                         xferCount
);

  localparam int VW = numVec * vecSize * regSize;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [ctrlSize-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [VW-1:0]         main_vec_q, main_vec_d, skid_vec_q, skid_vec_d;
  logic [vecSize-1:0]    main_mask_q, main_mask_d, skid_mask_q, skid_mask_d;
  logic [VW-1:0]         in_vec_m;
  logic                  out_valid;
  logic                  accept;
  logic                  consume;

  assign out_valid = (state_q != EMPTY);
  assign accept    = inValid & ready_q;
  assign consume   = out_valid & outReady;

  // Dead lanes are zeroed once at capture so the stored entry is already clean.
  always_comb begin
    in_vec_m = inVec;
    for (int v = 0; v < numVec; v++) begin
      for (int l = 0; l < vecSize; l++) begin
        if (!inLaneMask[l]) begin
          in_vec_m[(v*vecSize+l)*regSize +: regSize] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_vec_d  = main_vec_q;
    main_mask_d = main_mask_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_vec_d  = skid_vec_q;
    skid_mask_d = skid_mask_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = inCtrl;
            main_vec_d  = in_vec_m;
            main_mask_d = inLaneMask;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_ctrl_d = inCtrl;
            main_vec_d  = in_vec_m;
            main_mask_d = inLaneMask;
          end else if (accept) begin
            skid_ctrl_d = inCtrl;
            skid_vec_d  = in_vec_m;
            skid_mask_d = inLaneMask;
            state_d     = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_ctrl_d = skid_ctrl_q;
            main_vec_d  = skid_vec_q;
            main_mask_d = skid_mask_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Payload is qualified by the state, so it carries no reset.
  always_ff @(posedge clk) begin
    main_ctrl_q <= main_ctrl_d;
    main_vec_q  <= main_vec_d;
    main_mask_q <= main_mask_d;
    skid_ctrl_q <= skid_ctrl_d;
    skid_vec_q  <= skid_vec_d;
    skid_mask_q <= skid_mask_d;
  end

  assign inReady     = ready_q;
  assign outValid    = out_valid;
  assign outCtrl     = out_valid ? main_ctrl_q : '0;
  assign outVec      = out_valid ? main_vec_q  : '0;
  assign outLaneMask = out_valid ? main_mask_q : '0;

`ifdef PIPE_VECT_SKID_STATS_EN
  logic [31:0] stall_q, stall_d, xfer_q, xfer_d;

  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (flush) begin
      stall_d = '0;
      xfer_d  = '0;
    end else begin
      if (out_valid && !outReady && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end
      if (consume && (xfer_q != 32'hFFFF_FFFF)) begin
        xfer_d = xfer_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign stallCount = stall_q;
  assign xferCount  = xfer_q;
`else
  assign stallCount = '0;
  assign xferCount  = '0;
`endif

endmodule

// File: tb/tb_pipe_vect_skid.sv
// tb/tb_pipe_vect_skid.sv - directed plus randomized checks of pipe_vect_skid against a queue model
module tb_pipe_vect_skid;

  localparam int CW = 33;
  localparam int RW = 16;
  localparam int LN = 4;
  localparam int NV = 3;
  localparam int VW = NV * LN * RW;
`ifdef PIPE_VECT_SKID_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [CW-1:0] inCtrl = '0;
  logic [VW-1:0] inVec = '0;
  logic [LN-1:0] inLaneMask = '1;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [CW-1:0] outCtrl;
  logic [VW-1:0] outVec;
  logic [LN-1:0] outLaneMask;
  logic [31:0]   stallCount;
  logic [31:0]   xferCount;

  pipe_vect_skid dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .inValid    (inValid),
    .inReady    (inReady),
    .inCtrl     (inCtrl),
    .inVec      (inVec),
    .inLaneMask (inLaneMask),
    .outValid   (outValid),
    .outReady   (outReady),
    .outCtrl    (outCtrl),
    .outVec     (outVec),
    .outLaneMask(outLaneMask),
    .stallCount (stallCount),
    .xferCount  (xferCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [VW-1:0] vec;
    logic [LN-1:0] mask;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_stall = 0;
  int   m_xfer = 0;
  bit   last_acc = 1'b0;

  function automatic logic [VW-1:0] mask_vec(input logic [VW-1:0] v, input logic [LN-1:0] m);
    for (int o = 0; o < NV; o++)
      for (int l = 0; l < LN; l++)
        if (!m[l]) v[(o*LN+l)*RW +: RW] = '0;
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 256'(inReady), 256'(q.size() < 2));
    chk("out_valid", 256'(outValid), 256'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_ctrl", 256'(outCtrl), 256'(q[0].ctrl));
      chk("out_vec", 256'(outVec), 256'(q[0].vec));
      chk("out_mask", 256'(outLaneMask), 256'(q[0].mask));
    end else begin
      chk("bubble_ctrl", 256'(outCtrl), 256'(0));
      chk("bubble_vec", 256'(outVec), 256'(0));
      chk("bubble_mask", 256'(outLaneMask), 256'(0));
    end
    chk("stall_count", 256'(stallCount), STATS ? 256'(m_stall) : 256'(0));
    chk("xfer_count", 256'(xferCount), STATS ? 256'(m_xfer) : 256'(0));
  endtask

  // Check the current outputs, then advance one clock and update the model.
  task automatic tick();
    bit acc, cons, fl, stall;
    ent_t e;
    check_all();
    acc   = inValid && (q.size() < 2);
    cons  = (q.size() > 0) && outReady;
    stall = (q.size() > 0) && !outReady;
    fl    = flush;
    e     = '{ctrl: inCtrl, vec: mask_vec(inVec, inLaneMask), mask: inLaneMask};
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_stall = 0;
      m_xfer  = 0;
      last_acc = 1'b1;
    end else begin
      if (stall) m_stall++;
      if (cons) begin
        void'(q.pop_front());
        m_xfer++;
      end
      if (acc) q.push_back(e);
      last_acc = acc;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    inValid    = v;
    inCtrl     = c;
    inVec      = rand_vec();
    inLaneMask = '1;
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    repeat (2) tick();

    // streaming: latency 1, back-to-back
    outReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i));
      tick();
      chk("stream_valid", 256'(outValid), 256'(1));
      chk("stream_ctrl", 256'(outCtrl), 256'(i));
    end
    inValid = 1'b0;
    repeat (2) tick();

    // skid fill then drain in order
    outReady = 1'b0;
    drive(1'b1, CW'(33'hA));
    tick();
    drive(1'b1, CW'(33'hB));
    tick();
    inValid = 1'b0;
    chk("full_ready", 256'(inReady), 256'(0));
    chk("full_head", 256'(outCtrl), 256'(33'hA));
    outReady = 1'b1;
    tick();
    chk("drain_b", 256'(outCtrl), 256'(33'hB));
    chk("drain_ready", 256'(inReady), 256'(1));
    tick();
    chk("drain_empty", 256'(outValid), 256'(0));

    // capture masking
    inValid    = 1'b1;
    inCtrl     = 33'h1_2345_6789;
    inVec      = '1;
    inLaneMask = 4'b0101;
    tick();
    inValid = 1'b0;
    chk("mask_vec", 256'(outVec), 256'({3{64'h0000_FFFF_0000_FFFF}}));
    chk("mask_ctrl", 256'(outCtrl), 256'(33'h1_2345_6789));
    chk("mask_lanes", 256'(outLaneMask), 256'(4'b0101));
    tick();

    // flush while full with input pending
    outReady = 1'b0;
    drive(1'b1, CW'(33'h11));
    tick();
    drive(1'b1, CW'(33'h22));
    tick();
    drive(1'b1, CW'(33'h77));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    inValid = 1'b0;
    chk("flush_valid", 256'(outValid), 256'(0));
    chk("flush_ready", 256'(inReady), 256'(1));
    chk("flush_ctrl", 256'(outCtrl), 256'(0));
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_gone", 256'(outValid), 256'(0));
    end

    // flush beats a same-cycle accept in ONE
    drive(1'b1, CW'(33'h33));
    tick();
    drive(1'b1, CW'(33'h55));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    inValid = 1'b0;
    chk("flush_acc", 256'(outValid), 256'(0));
    tick();

    // statistics counters
    flush = 1'b1;
    tick();
    flush = 1'b0;
    outReady = 1'b0;
    drive(1'b1, CW'(33'h1));
    tick();
    drive(1'b1, CW'(33'h2));
    tick();
    inValid = 1'b0;
    repeat (4) tick();
    outReady = 1'b1;
    drive(1'b0, CW'(33'h3));
    tick();
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    outReady = 1'b0;
    chk("stats_stall", 256'(stallCount), STATS ? 256'(5) : 256'(0));
    chk("stats_xfer", 256'(xferCount), STATS ? 256'(3) : 256'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stats_clr_stall", 256'(stallCount), 256'(0));
    chk("stats_clr_xfer", 256'(xferCount), 256'(0));

    // randomized traffic with occasional flush
    last_acc = 1'b1;
    inValid  = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!(inValid && !last_acc)) begin
        inValid    = ($urandom_range(0, 3) != 0);
        inCtrl     = {1'($urandom), $urandom};
        inVec      = rand_vec();
        inLaneMask = 4'($urandom);
      end
      outReady = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0;

    // asynchronous reset in the middle of a stall
    inValid  = 1'b0;
    outReady = 1'b0;
    drive(1'b1, CW'(33'h44));
    tick();
    drive(1'b1, CW'(33'h66));
    tick();
    inValid = 1'b0;
    #2;
    rst = 1'b0;
    q.delete();
    m_stall = 0;
    m_xfer  = 0;
    #1;
    check_all();
    chk("rst_ready", 256'(inReady), 256'(1));
    #1;
    rst = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
